// File: rtl/io_input_pkg.sv
// rtl/io_input_pkg.sv - shared constants for the IO input port
package io_input_pkg;

  localparam logic       RS_DATA        = 1'b0;
  localparam logic       RS_STATUS      = 1'b1;

  localparam int         ST_NOT_EMPTY   = 0;
  localparam int         ST_FULL        = 1;
  localparam int         ST_UNDERFLOW   = 2;
  localparam int         ST_COUNT_LSB   = 4;

  localparam logic [7:0] UNDERFLOW_BYTE = 8'h00;

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - DEPTH-entry byte FIFO with registered occupancy count
module byte_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          out_rst,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage needs no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge out_rst) begin
    if (out_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_input_port.sv
// rtl/io_input_port.sv - host-fed byte FIFO read by the CPU over io_bus
// Optional IO_INPUT_PORT_IRQ_EN adds a registered active-low irq_n output.
module io_input_port
  import io_input_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic       clk,
  input  logic       out_rst,
  inout  wire  [7:0] io_bus,
  input  logic       sel_n,
  input  logic       rs,
  input  logic       from_devn,
  input  logic [7:0] host_data,
  input  logic       host_valid,
  output logic       host_ready
`ifdef IO_INPUT_PORT_IRQ_EN
  ,
  output logic       irq_n
`endif
);

  logic          rd;
  logic          data_rd;
  logic          status_rd;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [AW:0]   fifo_count;
  logic          underflow;
  logic [7:0]    status;
  logic          bus_oe;
  logic [7:0]    bus_out;

  assign rd         = !sel_n && !from_devn;
  assign data_rd    = rd && (rs == RS_DATA);
  assign status_rd  = rd && (rs == RS_STATUS);
  assign host_ready = !fifo_full;

  byte_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .out_rst (out_rst),
    .push    (host_valid),
    .din     (host_data),
    .pop     (data_rd),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    status                              = '0;
    status[ST_NOT_EMPTY]                = !fifo_empty;
    status[ST_FULL]                     = fifo_full;
    status[ST_UNDERFLOW]                = underflow;
    status[ST_COUNT_LSB +: 4]           = 4'(fifo_count);
  end

  // Data and status reads are mutually exclusive, so set and clear never collide.
  always_ff @(posedge clk or posedge out_rst) begin
    if (out_rst)                     underflow <= 1'b0;
    else if (data_rd && fifo_empty)  underflow <= 1'b1;
    else if (status_rd)              underflow <= 1'b0;
  end

  always_comb begin
    bus_oe  = rd && !out_rst;
    bus_out = '0;
    if (status_rd)        bus_out = status;
    else if (fifo_empty)  bus_out = UNDERFLOW_BYTE;
    else                  bus_out = fifo_dout;
  end

  assign io_bus = bus_oe ? bus_out : 8'hzz;

`ifdef IO_INPUT_PORT_IRQ_EN
  always_ff @(posedge clk or posedge out_rst) begin
    if (out_rst) irq_n <= 1'b1;
    else         irq_n <= fifo_empty;
  end
`endif

endmodule

// File: tb/tb_io_input_port.sv
// tb/tb_io_input_port.sv - directed self-checking bench for io_input_port
module tb_io_input_port;

  logic       clk        = 1'b0;
  logic       out_rst    = 1'b1;
  logic       sel_n      = 1'b1;
  logic       rs         = 1'b0;
  logic       from_devn  = 1'b1;
  logic [7:0] host_data  = 8'h00;
  logic       host_valid = 1'b0;
  logic       host_ready;
  wire  [7:0] io_bus;
`ifdef IO_INPUT_PORT_IRQ_EN
  logic       irq_n;
`endif

  int tests  = 0;
  int failed = 0;

  // Undriven bus floats to FF so a released bus is observable.
  pullup (io_bus);

  always #5 clk = ~clk;

  io_input_port #(.DEPTH(8), .AW(3)) dut (
    .clk        (clk),
    .out_rst    (out_rst),
    .io_bus     (io_bus),
    .sel_n      (sel_n),
    .rs         (rs),
    .from_devn  (from_devn),
    .host_data  (host_data),
    .host_valid (host_valid),
    .host_ready (host_ready)
`ifdef IO_INPUT_PORT_IRQ_EN
    ,
    .irq_n      (irq_n)
`endif
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_reg(input logic r, input string tag, input logic [7:0] exp);
    sel_n     = 1'b0;
    from_devn = 1'b0;
    rs        = r;
    #3;
    check(tag, io_bus, exp);
    step();
    sel_n     = 1'b1;
    from_devn = 1'b1;
  endtask

  task automatic push(input logic [7:0] d);
    host_valid = 1'b1;
    host_data  = d;
    step();
    host_valid = 1'b0;
  endtask

  initial begin
    #2;
    check("rst_ready", 8'(host_ready), 8'h01);
    check("rst_bus_z", io_bus, 8'hff);
    repeat (2) @(posedge clk);
    #1;
    out_rst = 1'b0;

    rd_reg(1'b1, "rst_status", 8'h00);
    check("rst_ready_after", 8'(host_ready), 8'h01);
    #3;
    check("idle_bus_z", io_bus, 8'hff);
    from_devn = 1'b0;
    #1;
    check("unselected_bus_z", io_bus, 8'hff);
    from_devn = 1'b1;
    step();

    push(8'h41);
    push(8'h42);
    rd_reg(1'b0, "rd_41", 8'h41);
    rd_reg(1'b0, "rd_42", 8'h42);
    rd_reg(1'b0, "rd_empty", 8'h00);
    rd_reg(1'b1, "status_underflow", 8'h04);
    rd_reg(1'b1, "status_cleared", 8'h00);

    for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
    check("full_ready", 8'(host_ready), 8'h00);
    rd_reg(1'b1, "status_full", 8'h83);
    host_valid = 1'b1;
    host_data  = 8'h99;
    sel_n      = 1'b0;
    from_devn  = 1'b0;
    rs         = 1'b0;
    #3;
    check("pop_full_data", io_bus, 8'h10);
    check("pop_full_ready", 8'(host_ready), 8'h00);
    step();
    sel_n     = 1'b1;
    from_devn = 1'b1;
    #3;
    check("ready_returns", 8'(host_ready), 8'h01);
    step();
    host_valid = 1'b0;
    rd_reg(1'b1, "status_refull", 8'h83);
    for (int i = 1; i < 8; i++) rd_reg(1'b0, "drain", 8'(8'h10 + i));
    rd_reg(1'b0, "drain_wrap_99", 8'h99);
    rd_reg(1'b1, "status_drained", 8'h00);

    push(8'haa);
    push(8'hbb);
    host_valid = 1'b1;
    host_data  = 8'h55;
    rd_reg(1'b0, "simul_rd_aa", 8'haa);
    host_valid = 1'b0;
    rd_reg(1'b1, "simul_count2", 8'h21);
    rd_reg(1'b0, "simul_rd_bb", 8'hbb);
    rd_reg(1'b0, "simul_rd_55", 8'h55);

    host_valid = 1'b1;
    host_data  = 8'h66;
    rd_reg(1'b0, "empty_push_rd", 8'h00);
    host_valid = 1'b0;
    rd_reg(1'b1, "empty_push_status", 8'h15);
    rd_reg(1'b1, "empty_push_cleared", 8'h11);
    rd_reg(1'b0, "rd_66", 8'h66);
    rd_reg(1'b1, "status_idle", 8'h00);

    push(8'h01);
    push(8'h02);
    push(8'h03);
    sel_n     = 1'b0;
    from_devn = 1'b0;
    rs        = 1'b0;
    #3;
    check("pre_reset_rd", io_bus, 8'h01);
    #1;
    out_rst = 1'b1;
    #1;
    check("reset_bus_z", io_bus, 8'hff);
    check("reset_ready", 8'(host_ready), 8'h01);
    step();
    sel_n     = 1'b1;
    from_devn = 1'b1;
    step();
    out_rst = 1'b0;
    rd_reg(1'b1, "post_reset_status", 8'h00);

`ifdef IO_INPUT_PORT_IRQ_EN
    check("irq_reset", 8'(irq_n), 8'h01);
    push(8'h77);
    check("irq_same_cycle", 8'(irq_n), 8'h01);
    step();
    check("irq_asserted", 8'(irq_n), 8'h00);
    rd_reg(1'b0, "irq_rd_77", 8'h77);
    check("irq_after_pop", 8'(irq_n), 8'h00);
    step();
    check("irq_released", 8'(irq_n), 8'h01);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
